controlador_multiplex_displays: RTL and testbench

Time-multiplexing controller for the 4-digit common-anode seven-segment array. Generates the per-digit refresh timing, inserts a blanking gap between digits to suppress ghosting, skips masked digits, and drives active-low anodes plus the BCD nibble for the current digit to the segment decoder. New display values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/controlador_multiplex_displays_pkg.sv | 19 +
 rtl/controlador_multiplex_displays_selector.sv | 25 ++
 rtl/controlador_multiplex_displays.sv | 118 +++++++++++
 tb/tb_controlador_multiplex_displays.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/controlador_multiplex_displays_pkg.sv
// Shared types and constants for the seven-segment multiplexing controller.
package controlador_multiplex_displays_pkg;

   typedef enum logic {
      ST_BLANCO    = 1'b0,
      ST_ENCENDIDO = 1'b1
   } estado_t;

   localparam logic [3:0] ANODOS_APAGADOS = 4'b1111;
   localparam int         NUM_DISPLAYS    = 4;

   // Counts 0..max-1, so $clog2(max) bits suffice; never narrower than one bit.
   function automatic int ancho_contador(input int ciclos_digito, input int ciclos_blanco);
      int maximo;
      maximo = (ciclos_digito > ciclos_blanco) ? ciclos_digito : ciclos_blanco;
      return (maximo < 2) ? 1 : $clog2(maximo);
   endfunction

endpackage

// File: rtl/controlador_multiplex_displays_selector.sv
// Wrap-order search for the next enabled digit, offsets 1..4 from the current one.
module selector_siguiente_display
   import controlador_multiplex_displays_pkg::*;
(
   input  logic [1:0]              actual,
   input  logic [NUM_DISPLAYS-1:0] mascara,
   output logic [1:0]              siguiente,
   output logic                    encontrado,
   output logic                    envuelto
);

   // Descending scan so the smallest offset is the one that sticks; offset 4 is the digit itself.
   always_comb begin
      siguiente  = actual;
      encontrado = 1'b0;
      for (int k = NUM_DISPLAYS; k >= 1; k--) begin
         if (mascara[actual + 2'(k)]) begin
            siguiente  = actual + 2'(k);
            encontrado = 1'b1;
         end
      end
      envuelto = (siguiente <= actual);
   end

endmodule

// File: rtl/controlador_multiplex_displays.sv
// Four-digit common-anode multiplexer: blank/lit FSM, masked digit skipping,
// and a double-buffered BCD value committed only at frame boundaries.
module controlador_multiplex_displays
   import controlador_multiplex_displays_pkg::*;
#(
   parameter int CICLOS_DIGITO = 50000,
   parameter int CICLOS_BLANCO = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] valorBCD,
   input  logic        cargar,
   input  logic [3:0]  mascaraHabil,
   output logic [3:0]  anodos,
   output logic [1:0]  displayActual,
   output logic [3:0]  bcdActual,
   output logic        finTrama,
   output logic        cargaPendiente
);

   localparam int               ANCHO      = ancho_contador(CICLOS_DIGITO, CICLOS_BLANCO);
   localparam logic [ANCHO-1:0] FIN_DIGITO = ANCHO'(CICLOS_DIGITO - 1);
   localparam logic [ANCHO-1:0] FIN_BLANCO = ANCHO'(CICLOS_BLANCO - 1);

   estado_t          estado, estado_sig;
   logic [ANCHO-1:0] contador;
   logic             expira;
   logic [1:0]       display_sig;
   logic [3:0]       anodos_sig;
   logic             frontera;
   logic [1:0]       siguiente;
   logic             encontrado;
   logic             envuelto;
   logic [15:0]      buffer_entrada;
   logic [15:0]      sombra;

   selector_siguiente_display u_selector (
      .actual     (displayActual),
      .mascara    (mascaraHabil),
      .siguiente  (siguiente),
      .encontrado (encontrado),
      .envuelto   (envuelto)
   );

   assign expira = (estado == ST_ENCENDIDO) ? (contador == FIN_DIGITO)
                                            : (contador == FIN_BLANCO);

   // The mask is only consulted on an expiry, so a mid-interval change never cuts it short.
   always_comb begin
      estado_sig  = estado;
      display_sig = displayActual;
      frontera    = 1'b0;
      if (expira) begin
         case (estado)
            ST_ENCENDIDO: begin
               estado_sig  = ST_BLANCO;
               display_sig = siguiente;
               frontera    = envuelto;
            end
            ST_BLANCO: begin
               if (mascaraHabil[displayActual]) begin
                  estado_sig = ST_ENCENDIDO;
               end else if (encontrado) begin
                  display_sig = siguiente;
                  frontera    = envuelto;
               end else begin
                  frontera = 1'b1;
               end
            end
            default: ;
         endcase
      end
      anodos_sig = ANODOS_APAGADOS;
      if (estado_sig == ST_ENCENDIDO) begin
         anodos_sig[display_sig] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado        <= ST_BLANCO;
         contador      <= '0;
         displayActual <= 2'd0;
         anodos        <= ANODOS_APAGADOS;
         finTrama      <= 1'b0;
      end else begin
         estado        <= estado_sig;
         contador      <= expira ? '0 : contador + 1'b1;
         displayActual <= display_sig;
         anodos        <= anodos_sig;
         finTrama      <= frontera;
      end
   end

   // A load landing on the boundary edge commits the older buffer and stays pending itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buffer_entrada <= 16'h0000;
         sombra         <= 16'h0000;
         cargaPendiente <= 1'b0;
      end else begin
         if (cargar) begin
            buffer_entrada <= valorBCD;
         end
         if (frontera && cargaPendiente) begin
            sombra <= buffer_entrada;
         end
         if (cargar) begin
            cargaPendiente <= 1'b1;
         end else if (frontera) begin
            cargaPendiente <= 1'b0;
         end
      end
   end

   assign bcdActual = sombra[{displayActual, 2'b00} +: 4];

endmodule

// File: tb/tb_controlador_multiplex_displays.sv
// Directed bench for the display multiplexer with a per-cycle expectation queue.
module tb_controlador_multiplex_displays;

   typedef struct {
      int         paso;
      logic [3:0] an;
      logic [1:0] disp;
      logic [3:0] bcd;
      logic       fin;
      logic       pend;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] valorBCD;
   logic        cargar;
   logic [3:0]  mascaraHabil;
   logic [3:0]  anodos;
   logic [1:0]  displayActual;
   logic [3:0]  bcdActual;
   logic        finTrama;
   logic        cargaPendiente;

   int   n_cmp = 0;
   int   n_mis = 0;
   exp_t sb[$];

   controlador_multiplex_displays #(
      .CICLOS_DIGITO (4),
      .CICLOS_BLANCO (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .valorBCD       (valorBCD),
      .cargar         (cargar),
      .mascaraHabil   (mascaraHabil),
      .anodos         (anodos),
      .displayActual  (displayActual),
      .bcdActual      (bcdActual),
      .finTrama       (finTrama),
      .cargaPendiente (cargaPendiente)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] d);
      logic [15:0] s;
      s = v >> (4 * d);
      return s[3:0];
   endfunction

   function automatic exp_t reposo(input int k, input logic [15:0] sh);
      exp_t e;
      e.paso = k;
      e.an   = 4'b1111;
      e.disp = 2'd0;
      e.bcd  = nibble(sh, 2'd0);
      e.fin  = 1'b0;
      e.pend = 1'b0;
      return e;
   endfunction

   // All four digits enabled: 2 blank + 4 lit per digit, 24-cycle frame.
   function automatic exp_t modelo_todos(input int k, input logic [15:0] sh, input logic pend);
      exp_t e;
      int   q, r, d;
      e = reposo(k, sh);
      q = k % 24;
      e.fin  = (k > 0) && (q == 0);
      e.pend = pend;
      if (q >= 2) begin
         r = q - 2;
         d = r / 6;
         if ((r % 6) < 4) begin
            e.disp = 2'(d);
            e.an[d] = 1'b0;
         end else begin
            e.disp = 2'((d + 1) % 4);
         end
      end
      e.bcd = nibble(sh, e.disp);
      return e;
   endfunction

   task automatic cmp(input string tag, input int paso, input logic [15:0] obs, input logic [15:0] esp);
      n_cmp++;
      assert (obs === esp) else begin
         n_mis++;
         $error("FAIL %s paso=%0d observed=%h expected=%h", tag, paso, obs, esp);
      end
   endtask

   task automatic comparar();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL scoreboard_empty observed=0 expected>0");
      end else begin
         e = sb.pop_front();
         cmp("anodos", e.paso, {12'h0, anodos}, {12'h0, e.an});
         cmp("displayActual", e.paso, {14'h0, displayActual}, {14'h0, e.disp});
         cmp("bcdActual", e.paso, {12'h0, bcdActual}, {12'h0, e.bcd});
         cmp("finTrama", e.paso, {15'h0, finTrama}, {15'h0, e.fin});
         cmp("cargaPendiente", e.paso, {15'h0, cargaPendiente}, {15'h0, e.pend});
      end
   endtask

   task automatic ciclo();
      @(posedge clk);
      #1;
      comparar();
   endtask

   task automatic aplicar_reset();
      reset  = 1'b1;
      cargar = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb.push_back(reposo(0, 16'h0000));
      comparar();
   endtask

   initial begin
      exp_t e;
      int   q, r;
      reset        = 1'b1;
      cargar       = 1'b0;
      valorBCD     = 16'h0000;
      mascaraHabil = 4'b1111;

      // All digits: full refresh sequence, then a mid-frame load committed at the next frame.
      aplicar_reset();
      for (int k = 1; k <= 95; k++) begin
         cargar   = (k == 51);
         valorBCD = 16'h1234;
         sb.push_back(modelo_todos(k, (k >= 72) ? 16'h1234 : 16'h0000, (k >= 51) && (k < 72)));
         ciclo();
      end
      cargar = 1'b0;

      // Digits 0 and 2 only, then mask switched to digit 3 while digit 2 is lit.
      mascaraHabil = 4'b0101;
      aplicar_reset();
      for (int k = 1; k <= 41; k++) begin
         mascaraHabil = (k <= 21) ? 4'b0101 : 4'b1000;
         e = reposo(k, 16'h0000);
         if (k < 24) begin
            q = k % 12;
            e.fin = (q == 0);
            if (q >= 2 && q <= 5) e.an = 4'b1110;
            if (q >= 6) e.disp = 2'd2;
            if (q >= 8) e.an = 4'b1011;
         end else begin
            r = (k - 24) % 6;
            e.disp = 2'd3;
            e.fin  = (r == 0) && (k >= 30);
            if (r >= 2) e.an = 4'b0111;
         end
         sb.push_back(e);
         ciclo();
      end

      // No digit enabled: boundary every blank interval; loads, including one on the boundary edge.
      mascaraHabil = 4'b0000;
      aplicar_reset();
      for (int k = 1; k <= 19; k++) begin
         cargar   = (k == 5) || (k == 13) || (k == 14);
         valorBCD = (k == 5) ? 16'h9876 : ((k == 13) ? 16'hAAAA : 16'h5555);
         e = reposo(k, 16'h0000);
         e.fin  = (k % 2 == 0);
         e.pend = (k == 5) || ((k >= 13) && (k < 16));
         e.bcd  = (k < 6) ? 4'h0 : ((k < 14) ? 4'h6 : ((k < 16) ? 4'hA : 4'h5));
         sb.push_back(e);
         ciclo();
      end
      cargar = 1'b0;

      // Asynchronous reset while digit 2 is lit with a load pending.
      mascaraHabil = 4'b1111;
      aplicar_reset();
      for (int k = 1; k <= 15; k++) begin
         cargar   = (k == 3);
         valorBCD = 16'h4321;
         sb.push_back(modelo_todos(k, 16'h0000, k >= 3));
         ciclo();
      end
      cargar = 1'b0;
      reset  = 1'b1;
      #1;
      sb.push_back(reposo(100, 16'h0000));
      comparar();
      #1;
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         sb.push_back(modelo_todos(k, 16'h0000, 1'b0));
         ciclo();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
